// File: rtl/minmax_window_pkg.sv
// Shared types for the minmax_window streaming statistics block.
// Holds the sample width, the FSM state encoding and the comparator result encoding.
package minmax_window_pkg;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DONE  = 2'd2
  } state_e;

  // One-hot compare result, bit order {lt, gt, eq}
  typedef enum logic [2:0] {
    CMP_EQ = 3'b001,
    CMP_GT = 3'b010,
    CMP_LT = 3'b100
  } cmp_e;

  function automatic cmp_e cmp_pack(input logic eq, input logic gt, input logic lt);
    return cmp_e'({lt, gt, eq});
  endfunction

endpackage

// File: rtl/minmax_window_mag_cmp4.sv
// 4-bit unsigned magnitude comparator; exactly one of the three outputs is high.
module mag_cmp4
  import minmax_window_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              a_eq_b,
  output logic              a_gt_b,
  output logic              a_lt_b
);

  always_comb begin
    a_eq_b = (a == b);
    a_gt_b = (a > b);
    a_lt_b = (a < b);
  end

endmodule

// File: rtl/minmax_window.sv
// Streaming window max/min/max-hit counter over WINDOW unsigned 4-bit samples.
// Two comparators track running max and min; result is held until consumed.
module minmax_window
  import minmax_window_pkg::*;
#(
  parameter int WINDOW = 8  // legal 2..15, keeps count and hits inside 4 bits
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_max,
  output logic [DATA_W-1:0] res_min,
  output logic [CNT_W-1:0]  res_max_hits
);

  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [CNT_W-1:0]    hits_q, hits_d;
  logic [DATA_W-1:0]   max_q, max_d;
  logic [DATA_W-1:0]   min_q, min_d;

  logic a_eq, a_gt, a_lt;
  logic b_eq, b_gt, b_lt;
  cmp_e cmp_max, cmp_min;
  logic accept;

  mag_cmp4 u_cmp_max (
    .a      (in_data),
    .b      (max_q),
    .a_eq_b (a_eq),
    .a_gt_b (a_gt),
    .a_lt_b (a_lt)
  );

  mag_cmp4 u_cmp_min (
    .a      (in_data),
    .b      (min_q),
    .a_eq_b (b_eq),
    .a_gt_b (b_gt),
    .a_lt_b (b_lt)
  );

  assign cmp_max = cmp_pack(a_eq, a_gt, a_lt);
  assign cmp_min = cmp_pack(b_eq, b_gt, b_lt);

  // Handshake flags come from registered state only
  assign in_ready  = (state_q != DONE);
  assign res_valid = (state_q == DONE);
  assign accept    = in_valid & in_ready & ~clr;

  assign res_max      = max_q;
  assign res_min      = min_q;
  assign res_max_hits = hits_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hits_d  = hits_q;
    max_d   = max_q;
    min_d   = min_q;

    unique case (state_q)
      EMPTY: begin
        if (accept) begin
          max_d   = in_data;
          min_d   = in_data;
          hits_d  = CNT_W'(1);
          count_d = CNT_W'(1);
          state_d = FILL;
        end
      end
      FILL: begin
        if (accept) begin
          count_d = count_q + CNT_W'(1);
          unique case (cmp_max)
            CMP_GT: begin
              max_d  = in_data;
              hits_d = CNT_W'(1);
            end
            CMP_EQ:  hits_d = hits_q + CNT_W'(1);
            default: ;
          endcase
          if (cmp_min == CMP_LT) min_d = in_data;
          if (count_d == WIN_LAST) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase

    // Abort wins over everything, including a result being taken this cycle
    if (clr) begin
      state_d = EMPTY;
      count_d = '0;
      hits_d  = '0;
      max_d   = '0;
      min_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      count_q <= '0;
      hits_q  <= '0;
      max_q   <= '0;
      min_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hits_q  <= hits_d;
      max_q   <= max_d;
      min_q   <= min_d;
    end
  end

endmodule

// File: tb/tb_minmax_window.sv
// Directed bench for minmax_window: queue-based window model checked every cycle
// plus literal expectations per window.
module tb_minmax_window;

  localparam int WINDOW = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       res_ready = 1'b1;
  logic       in_ready, res_valid;
  logic [3:0] res_max, res_min, res_max_hits;

  int checks = 0;
  int errors = 0;

  minmax_window #(.WINDOW(WINDOW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_max      (res_max),
    .res_min      (res_min),
    .res_max_hits (res_max_hits)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: collect accepted samples, compute stats when the window is full
  int mq[$];
  bit m_done = 1'b0;
  bit m_zero = 1'b1;
  int m_max = 0, m_min = 0, m_hits = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); m_done = 1'b0; m_zero = 1'b1;
    end else if (clr) begin
      mq.delete(); m_done = 1'b0; m_zero = 1'b1;
    end else if (m_done) begin
      if (res_ready) m_done = 1'b0;
    end else if (in_valid) begin
      mq.push_back(int'(in_data));
      m_zero = 1'b0;
      if (mq.size() == WINDOW) begin
        m_max = mq[0]; m_min = mq[0]; m_hits = 0;
        foreach (mq[i]) begin
          if (mq[i] > m_max) m_max = mq[i];
          if (mq[i] < m_min) m_min = mq[i];
        end
        foreach (mq[i]) if (mq[i] == m_max) m_hits++;
        m_done = 1'b1;
        mq.delete();
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready", int'(in_ready), int'(!m_done));
    chk("res_valid", int'(res_valid), int'(m_done));
    if (m_done) begin
      chk("res_max", int'(res_max), m_max);
      chk("res_min", int'(res_min), m_min);
      chk("res_hits", int'(res_max_hits), m_hits);
    end else if (m_zero) begin
      chk("zero_max", int'(res_max), 0);
      chk("zero_min", int'(res_min), 0);
      chk("zero_hits", int'(res_max_hits), 0);
    end
  end

  // Offer one sample until accepted; inputs change 2 time units after posedge
  task automatic send(input logic [3:0] d);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    do begin
      acc = in_ready;
      @(posedge clk); #2;
      n++;
    end while (!acc && n < 50);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send_all(input logic [31:0] s);
    for (int i = 0; i < 8; i++) send(s[31-4*i -: 4]);
  endtask

  task automatic run_window(input logic [31:0] s, input int emax, input int emin,
                            input int ehits, input string tag);
    send_all(s);
    chk({tag, "_valid"}, int'(res_valid), 1);
    chk({tag, "_max"}, int'(res_max), emax);
    chk({tag, "_min"}, int'(res_min), emin);
    chk({tag, "_hits"}, int'(res_max_hits), ehits);
    @(posedge clk); #2;
    chk({tag, "_valid_drop"}, int'(res_valid), 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_max", int'(res_max), 0);
    chk("rst_min", int'(res_min), 0);
    chk("rst_hits", int'(res_max_hits), 0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_window(32'h3919_4907, 9, 0, 3, "basic");
    run_window(32'h5555_5555, 5, 5, 8, "equal");
    run_window(32'hF0F0_F0F0, 15, 0, 4, "extreme");
    run_window(32'hFEDC_BA98, 15, 8, 1, "desc");

    // Backpressure: result held, further samples refused
    res_ready = 1'b0;
    send_all(32'h2661_3654);
    in_valid = 1'b1;
    in_data  = 4'd2;
    repeat (5) begin
      chk("bp_valid", int'(res_valid), 1);
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_max", int'(res_max), 6);
      chk("bp_min", int'(res_min), 1);
      chk("bp_hits", int'(res_max_hits), 3);
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_valid", int'(res_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);

    // clr mid-window drops the offered sample and the partial window
    for (int i = 7; i <= 10; i++) send(4'(i));
    clr = 1'b1; in_valid = 1'b1; in_data = 4'd15;
    @(posedge clk); #2;
    clr = 1'b0; in_valid = 1'b0;
    chk("clr_max", int'(res_max), 0);
    chk("clr_hits", int'(res_max_hits), 0);
    chk("clr_ready", int'(in_ready), 1);
    run_window(32'h442B_3B61, 11, 1, 2, "post_clr");

    // clr while DONE with res_ready high
    send_all(32'h1234_5678);
    chk("done_clr_pre", int'(res_valid), 1);
    clr = 1'b1;
    @(posedge clk); #2;
    clr = 1'b0;
    chk("done_clr_valid", int'(res_valid), 0);
    chk("done_clr_max", int'(res_max), 0);
    chk("done_clr_ready", int'(in_ready), 1);
    run_window(32'hC3C3_7A7A, 12, 3, 2, "after_done_clr");

    // Asynchronous reset between edges mid-fill
    send(4'd9); send(4'd9); send(4'd9);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(res_valid), 0);
    chk("arst_ready", int'(in_ready), 1);
    chk("arst_max", int'(res_max), 9 - 9);
    chk("arst_min", int'(res_min), 0);
    chk("arst_hits", int'(res_max_hits), 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #2;
    run_window(32'h1234_5678, 8, 1, 1, "post_arst");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/minmax_window.md
# minmax_window

Streaming 4-bit window statistics unit built around the team's 4-bit magnitude comparator. It accepts unsigned 4-bit samples over a valid/ready handshake and feeds each sample, together with the running maximum and minimum, into two comparator instances. From their eq/gt/lt results it tracks the window maximum, window minimum and the number of samples equal to the maximum. After WINDOW samples it presents the result on a valid/ready output port.

## Interface
- WINDOW, 8: samples per window; legal range 2..15.
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low; one clock domain only
- clr  in  1  synchronous abort, active-high; discards the current window
- in_valid  in  1  sample offered
- in_ready  out  1  block can accept a sample
- in_data  in  4  unsigned sample
- res_valid  out  1  window result available
- res_ready  in  1  consumer accepts the result
- res_max  out  4  window maximum
- res_min  out  4  window minimum
- res_max_hits  out  4  samples in the window equal to res_max (1..WINDOW)

## Operation
- Accept: a sample is accepted when in_valid & in_ready & ~clr.
- State EMPTY:
  - in_ready=1, res_valid=0.
  - On accept: max=min=in_data, hits=1, count=1, go to FILL.
- State FILL:
  - in_ready=1, res_valid=0.
  - Comparator A compares in_data against max. Comparator B compares in_data against min.
  - Max update on accept: if gt, max=in_data and hits=1. If eq, hits=hits+1. If lt, max is unchanged.
  - Min update on accept: if B's lt, min=in_data; otherwise min is unchanged.
  - count=count+1 on each accept. When the incremented count equals WINDOW, go to DONE.
- State DONE:
  - in_ready=0, res_valid=1.
  - res_* hold the final values and stay stable until the result is taken.
  - When res_ready is high, go to EMPTY.
- Outputs outside DONE: res_max, res_min and res_max_hits show the live running registers. Their contents are meaningful only while res_valid=1.
- clr:
  - From any state, the next state is EMPTY.
  - count, max, min and hits are cleared to 0.
  - A sample offered in the clr cycle is not accepted.
  - A result presented in DONE is dropped, even if res_ready is high in the same cycle.
- Widths: count is 4 bits and hits is 4 bits. WINDOW ≤ 15, so neither can overflow.

## Timing
- Reset values: state=EMPTY, in_ready=1, res_valid=0, res_max=0, res_min=0, res_max_hits=0, count=0.
- in_ready and res_valid are decoded from registered state only, with no combinational path from in_valid or res_ready.
- Comparators are combinational. The register update happens on the same clock edge as the accept.
- Latency: res_valid rises on the edge that accepts the WINDOW-th sample, so it is visible in the following cycle.
- Result handshake and restart:
  - With res_ready held high, DONE lasts exactly one cycle and in_ready returns the cycle after.
  - Throughput is WINDOW samples per WINDOW+1 cycles.
- Backpressure: res_valid and res_* stay stable until res_ready is seen high.
- rst_n asserted mid-window: all state and outputs go to reset values immediately, without waiting for clk.

## Structure
- Shared package holds:
  - DATA_W = 4.
  - The state enum {EMPTY, FILL, DONE}.
  - The compare-result encoding (EQ, GT, LT one-hot).
- Natural sub-module: mag_cmp4.
  - Inputs: 4-bit A and B.
  - Outputs: AeqB, AgtB, AltB.
  - Exactly one output is high for any input pair.
- minmax_window instantiates mag_cmp4 twice (max path, min path) and holds the FSM, counters and registers.

## Test plan
- Reset, then WINDOW=8 samples 3,9,1,9,4,9,0,7 with res_ready=1 -> res_valid high for 1 cycle with res_max=9, res_min=0, res_max_hits=3. in_ready returns the next cycle.
- All-equal window: eight samples of 5 -> res_max=5, res_min=5, res_max_hits=8.
- Extremes: 15,0,15,0,... -> max=15, min=0, hits=4. Then a descending window 15..8 -> max=15, hits=1, min=8.
- Backpressure: res_ready=0 for 5 cycles after res_valid -> res_valid and res_* stable, in_ready=0, offered samples not accepted. Assert res_ready -> EMPTY next cycle.
- clr asserted after 4 samples (with in_valid high in that cycle) -> that sample is dropped. A new 8-sample window then yields results from the new samples only. clr while in DONE with res_ready=1 -> result dropped, state EMPTY.
- rst_n pulsed low between clock edges mid-FILL -> outputs at reset values immediately. The first window after release is correct.
